// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR chain widths, sample type and round/saturate helper
package fir_pkg;

    localparam int FIR_OUT_W = 10;
    localparam int DEF_OUT_W = 8;

    typedef logic signed [FIR_OUT_W-1:0] fir_sample_t;

    // Round half-up, arithmetic shift, clamp to a signed out_w range; 32 bits covers any sum here.
    function automatic logic signed [31:0] sat_round(input logic signed [31:0] value,
                                                     input int shift,
                                                     input int out_w);
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        r  = (shift > 0) ? ((value + (32'sd1 <<< (shift - 1))) >>> shift) : value;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - show-ahead synchronous FIFO with full/empty/count
module fir_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_pop    = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// rtl/fir_out_decimator.sv - FIR output decimate/round/saturate into a FIFO; FIR_DEC_AVG_EN sums each window
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_OUT_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DECIM = 2,
    parameter int SHIFT = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din_valid,
    input  logic [IN_W-1:0]            din,
    input  logic                       dout_ready,
    output logic                       dout_valid,
    output logic [OUT_W-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       clr_ovf,
    output logic                       ovf
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PH_W-1:0]   phase_q, phase_d;
    logic              stage_valid_q, stage_valid_d;
    logic [OUT_W-1:0]  stage_data_q, stage_data_d;
    logic              ovf_q, ovf_d;
    logic              keep;
    logic              fifo_full, fifo_empty, drop;
    logic signed [31:0] scale_in;
    logic [OUT_W-1:0]  scaled;

    assign keep = din_valid && (phase_q == PH_W'(DECIM - 1));

`ifdef FIR_DEC_AVG_EN
    localparam int AW = IN_W + $clog2(DECIM);

    logic signed [AW-1:0] acc_q, acc_d, win_sum;

    always_comb begin
        win_sum  = (phase_q == '0) ? AW'($signed(din)) : acc_q + AW'($signed(din));
        acc_d    = din_valid ? win_sum : acc_q;
        scale_in = 32'(win_sum);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign scale_in = 32'($signed(din));
`endif

    assign scaled = OUT_W'(sat_round(scale_in, SHIFT, OUT_W));

    // Full FIFO with no pop this cycle: the staged sample is lost.
    assign drop = stage_valid_q && fifo_full && !dout_ready;

    always_comb begin
        phase_d       = phase_q;
        stage_valid_d = keep;
        stage_data_d  = stage_data_q;
        ovf_d         = ovf_q;
        if (din_valid) begin
            phase_d = keep ? '0 : phase_q + 1'b1;
        end
        if (keep) begin
            stage_data_d = scaled;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            ovf_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            ovf_q         <= ovf_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stage_valid_q),
        .push_data (stage_data_q),
        .pop       (dout_ready),
        .head_data (dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign dout_valid = !fifo_empty;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// tb/tb_fir_out_decimator.sv - directed bench for fir_out_decimator (DECIM=2 and DECIM=1 instances)
module tb_fir_out_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       rst2, din_valid2, dout_ready2, clr_ovf2, dout_valid2, ovf2;
    logic [9:0] din2;
    logic [7:0] dout2;
    logic [2:0] count2;

    logic       rst1, din_valid1, dout_ready1, clr_ovf1, dout_valid1, ovf1;
    logic [9:0] din1;
    logic [7:0] dout1;
    logic [2:0] count1;

    fir_out_decimator #(.IN_W(10), .OUT_W(8), .DECIM(2), .SHIFT(2), .DEPTH(4)) dut2 (
        .clk(clk), .rst(rst2), .din_valid(din_valid2), .din(din2), .dout_ready(dout_ready2),
        .dout_valid(dout_valid2), .dout(dout2), .count(count2), .clr_ovf(clr_ovf2), .ovf(ovf2)
    );

    fir_out_decimator #(.IN_W(10), .OUT_W(8), .DECIM(1), .SHIFT(2), .DEPTH(4)) dut1 (
        .clk(clk), .rst(rst1), .din_valid(din_valid1), .din(din1), .dout_ready(dout_ready1),
        .dout_valid(dout_valid1), .dout(dout1), .count(count1), .clr_ovf(clr_ovf1), .ovf(ovf1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push1(input int v);
        din_valid1 = 1'b1;
        din1 = 10'(v);
        tick();
    endtask

    initial begin
        rst2 = 1'b0; din_valid2 = 1'b0; din2 = '0; dout_ready2 = 1'b0; clr_ovf2 = 1'b0;
        rst1 = 1'b0; din_valid1 = 1'b0; din1 = '0; dout_ready1 = 1'b0; clr_ovf1 = 1'b0;
        tick();
        tick();
        rst2 = 1'b1;
        rst1 = 1'b1;
        chk("rst_valid2", 32'(dout_valid2), 0);
        chk("rst_count2", 32'(count2), 0);
        chk("rst_ovf2", 32'(ovf2), 0);
        chk("rst_dout2", 32'(dout2), 0);
        chk("rst_valid1", 32'(dout_valid1), 0);
        chk("rst_dout1", 32'(dout1), 0);

        // Decimate by 2: 100,20,30,40 keeps 20 and 40
        dout_ready2 = 1'b1;
        din_valid2 = 1'b1; din2 = 10'd100; tick();
        din2 = 10'd20; tick();
        chk("dec_not_yet", 32'(dout_valid2), 0);
        din2 = 10'd30; tick();
        chk("dec_valid_a", 32'(dout_valid2), 1);
        chk("dec_dout_a", $signed(dout2), 5);
        chk("dec_count_a", 32'(count2), 1);
        din2 = 10'd40; tick();
        chk("dec_gap", 32'(dout_valid2), 0);
        chk("dec_gap_count", 32'(count2), 0);
        din_valid2 = 1'b0; tick();
        chk("dec_valid_b", 32'(dout_valid2), 1);
        chk("dec_dout_b", $signed(dout2), 10);
        chk("dec_count_b", 32'(count2), 1);
        tick();
        chk("dec_drained", 32'(dout_valid2), 0);
        dout_ready2 = 1'b0;

        // Rounding and saturation with DECIM=1
        push1(102); push1(-6); push1(511); push1(-512);
        din_valid1 = 1'b0; tick();
        chk("rnd_count", 32'(count1), 4);
        chk("rnd_ovf", 32'(ovf1), 0);
        dout_ready1 = 1'b1;
        chk("rnd_102", $signed(dout1), 26);
        tick();
        chk("rnd_m6", $signed(dout1), -1);
        tick();
        chk("sat_511", $signed(dout1), 127);
        tick();
        chk("sat_m512", $signed(dout1), -128);
        tick();
        chk("rnd_empty", 32'(dout_valid1), 0);
        dout_ready1 = 1'b0;

        // Overflow: five pushes into a depth-4 FIFO
        push1(4); push1(8); push1(12); push1(16); push1(20);
        din_valid1 = 1'b0; tick();
        tick();
        chk("ovf_count", 32'(count1), 4);
        chk("ovf_set", 32'(ovf1), 1);
        chk("ovf_hold", $signed(dout1), 1);
        dout_ready1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_out%0d", i), $signed(dout1), i);
            tick();
        end
        chk("ovf_empty", 32'(dout_valid1), 0);
        dout_ready1 = 1'b0;
        clr_ovf1 = 1'b1; tick();
        clr_ovf1 = 1'b0;
        chk("ovf_clr", 32'(ovf1), 0);

        // Push and pop together while full
        push1(4); push1(8); push1(12); push1(16); push1(20);
        din_valid1 = 1'b0; dout_ready1 = 1'b1; tick();
        dout_ready1 = 1'b0;
        chk("pp_count", 32'(count1), 4);
        chk("pp_head", $signed(dout1), 2);
        chk("pp_ovf", 32'(ovf1), 0);
        push1(24);
        din_valid1 = 1'b0; clr_ovf1 = 1'b1; tick();
        clr_ovf1 = 1'b0;
        chk("pp_set_wins", 32'(ovf1), 1);
        chk("pp_count_drop", 32'(count1), 4);
        dout_ready1 = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("pp_out%0d", i), $signed(dout1), i);
            tick();
        end
        chk("pp_empty", 32'(dout_valid1), 0);
        dout_ready1 = 1'b0;

        // Reset mid-stream: 3 entries buffered, phase=1
        din_valid2 = 1'b1;
        din2 = 10'd0;  tick(); din2 = 10'd4;  tick();
        din2 = 10'd0;  tick(); din2 = 10'd8;  tick();
        din2 = 10'd0;  tick(); din2 = 10'd12; tick();
        din2 = 10'd0;  tick();
        din_valid2 = 1'b0; tick();
        chk("mid_count", 32'(count2), 3);
        chk("mid_head", $signed(dout2), 1);
        rst2 = 1'b0; tick();
        rst2 = 1'b1;
        chk("mid_rst_valid", 32'(dout_valid2), 0);
        chk("mid_rst_count", 32'(count2), 0);
        chk("mid_rst_ovf", 32'(ovf2), 0);
        din_valid2 = 1'b1; din2 = 10'd40; tick();
        din2 = 10'd44; tick();
        din_valid2 = 1'b0; tick();
        chk("mid_valid", 32'(dout_valid2), 1);
        chk("mid_dout", $signed(dout2), 11);
        chk("mid_count1", 32'(count2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
